// File: rtl/uart_rx_pkg.sv
// Shared types and elaboration helpers for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tick at which the sampler's majority vote for the current bit is settled.
  function automatic int midTick(input int prescale);
    return prescale / 2 + 2;
  endfunction

  // One tick later the registered checker results are valid.
  function automatic int captTick(input int prescale);
    return midTick(prescale) + 1;
  endfunction

  function automatic logic isBitState(input state_t s);
    return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling tick counter and data-bit counter for one UART frame.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_count_en,
  input  logic                            i_clear,
  input  logic                            i_bit_en,
  output logic [cntWidth(PRESCALE)-1:0]   o_edge_cnt,
  output logic [cntWidth(DATA_WIDTH)-1:0] o_bit_cnt,
  output logic                            o_bit_end
);

  localparam int EW = cntWidth(PRESCALE);
  localparam int BW = cntWidth(DATA_WIDTH);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  logic [EW-1:0] r_edgeCnt;
  logic [BW-1:0] r_bitCnt;

  assign o_bit_end  = (r_edgeCnt == EDGE_LAST);
  assign o_edge_cnt = r_edgeCnt;
  assign o_bit_cnt  = r_bitCnt;

  // The bit counter only advances when a data bit finishes its last tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edgeCnt <= '0;
      r_bitCnt  <= '0;
    end else if (i_clear) begin
      r_edgeCnt <= '0;
      r_bitCnt  <= '0;
    end else if (i_count_en) begin
      r_edgeCnt <= o_bit_end ? '0 : r_edgeCnt + EW'(1);
      if (i_bit_en && o_bit_end) begin
        r_bitCnt <= (r_bitCnt == BIT_LAST) ? '0 : r_bitCnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: sequences sampling and bit checks over one
// frame and reports it as valid, parity-error or frame-error.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_rx_in,
  input  logic                          i_parity_enable,
  input  logic                          i_start_glitch,
  input  logic                          i_parity_ok,
  input  logic                          i_stop_error,
  output logic [cntWidth(PRESCALE)-1:0] o_edge_cnt,
  output logic                          o_sampler_enable,
  output logic                          o_deser_enable,
  output logic                          o_start_check_enable,
  output logic                          o_parity_check_enable,
  output logic                          o_stop_check_enable,
  output logic                          o_data_valid,
  output logic                          o_parity_error,
  output logic                          o_frame_error
);

  localparam int EW = cntWidth(PRESCALE);
  localparam int BW = cntWidth(DATA_WIDTH);
  localparam logic [EW-1:0] PRE_MID  = EW'(midTick(PRESCALE) - 1);
  localparam logic [EW-1:0] CAPT     = EW'(captTick(PRESCALE));
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  if (PRESCALE < 8 || (PRESCALE % 2) != 0) begin : g_badPrescale
    $error("uart_rx_fsm: PRESCALE must be even and at least 8");
  end

  state_t        r_state, w_nextState;
  logic          r_parEn, r_parErr;
  logic [EW-1:0] w_edgeCnt;
  logic [BW-1:0] w_bitCnt;
  logic          w_bitEnd, w_atCapt, w_countEn;
  logic          w_samplerNext, w_deserNext, w_startChkNext, w_parChkNext, w_stopChkNext;
  logic          w_validNext, w_parErrNext, w_frameErrNext;

  assign w_atCapt   = (w_edgeCnt == CAPT);
  assign w_countEn  = isBitState(r_state) && isBitState(w_nextState);
  assign o_edge_cnt = w_edgeCnt;

  uart_rx_edge_bit_counter #(
    .PRESCALE   (PRESCALE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_count_en (w_countEn),
    .i_clear    (~w_countEn),
    .i_bit_en   (r_state == DATA),
    .o_edge_cnt (w_edgeCnt),
    .o_bit_cnt  (w_bitCnt),
    .o_bit_end  (w_bitEnd)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nextState;
  end

  // A start glitch outranks the end-of-bit move into DATA when both land on one tick.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!i_rx_in) w_nextState = START;
      START: begin
        if (w_atCapt && i_start_glitch) w_nextState = IDLE;
        else if (w_bitEnd)              w_nextState = DATA;
      end
      DATA:    if (w_bitEnd && (w_bitCnt == BIT_LAST)) w_nextState = r_parEn ? PARITY : STOP;
      PARITY:  if (w_bitEnd) w_nextState = STOP;
      STOP:    if (w_atCapt) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_parEn  <= 1'b0;
      r_parErr <= 1'b0;
    end else begin
      if (r_state == IDLE)                r_parEn  <= i_parity_enable;
      if (r_state == PARITY && w_atCapt)  r_parErr <= ~i_parity_ok;
      if (r_state == DONE)                r_parErr <= 1'b0;
    end
  end

  // Strobes are set one tick early so the registered copy lines up with tick MID.
  always_comb begin
    w_samplerNext  = isBitState(w_nextState);
    w_startChkNext = (r_state == START)  && (w_edgeCnt == PRE_MID);
    w_deserNext    = (r_state == DATA)   && (w_edgeCnt == PRE_MID);
    w_parChkNext   = (r_state == PARITY) && (w_edgeCnt == PRE_MID);
    w_stopChkNext  = (r_state == STOP)   && (w_edgeCnt == PRE_MID);
    w_parErrNext   = (w_nextState == DONE) && r_parErr;
    w_frameErrNext = (w_nextState == DONE) && i_stop_error;
    w_validNext    = (w_nextState == DONE) && !r_parErr && !i_stop_error;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sampler_enable      <= 1'b0;
      o_deser_enable        <= 1'b0;
      o_start_check_enable  <= 1'b0;
      o_parity_check_enable <= 1'b0;
      o_stop_check_enable   <= 1'b0;
      o_data_valid          <= 1'b0;
      o_parity_error        <= 1'b0;
      o_frame_error         <= 1'b0;
    end else begin
      o_sampler_enable      <= w_samplerNext;
      o_deser_enable        <= w_deserNext;
      o_start_check_enable  <= w_startChkNext;
      o_parity_check_enable <= w_parChkNext;
      o_stop_check_enable   <= w_stopChkNext;
      o_data_valid          <= w_validNext;
      o_parity_error        <= w_parErrNext;
      o_frame_error         <= w_frameErrNext;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: each frame is expanded into a per-cycle timeline of
// expected outputs, then compared against the DUT every cycle.
module tb_uart_rx_fsm;

  localparam int P    = 8;
  localparam int W    = 8;
  localparam int MID  = P / 2 + 2;
  localparam int CAPT = MID + 1;

  typedef enum int {PH_IDLE, PH_START, PH_DATA, PH_PAR, PH_STOP, PH_DONE} ph_t;

  typedef struct {
    ph_t  ph;
    int   tick;
    logic rx;
    logic samp, deser, startChk, parChk, stopChk, valid, parErr, frmErr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN, rxIn, parityEnable, startGlitch, parityOk, stopError;
  logic [2:0] edgeCnt;
  logic       samplerEn, deserEn, startChkEn, parChkEn, stopChkEn;
  logic       dataValid, parityError, frameError;

  int   total = 0;
  int   bad = 0;
  exp_t expQ[$];
  exp_t curEntry;
  int   frameId = 0;
  int   seenId = 0;
  int   cyc = 0;
  int   validCyc = -1;
  int   parErrCyc = -1;
  int   frmErrCyc = -1;
  int   deserCnt = 0;
  int   strobeCnt = 0;
  logic fGlitch, fParOk, fStopErr;

  uart_rx_fsm #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rstN),
    .i_rx_in               (rxIn),
    .i_parity_enable       (parityEnable),
    .i_start_glitch        (startGlitch),
    .i_parity_ok           (parityOk),
    .i_stop_error          (stopError),
    .o_edge_cnt            (edgeCnt),
    .o_sampler_enable      (samplerEn),
    .o_deser_enable        (deserEn),
    .o_start_check_enable  (startChkEn),
    .o_parity_check_enable (parChkEn),
    .o_stop_check_enable   (stopChkEn),
    .o_data_valid          (dataValid),
    .o_parity_error        (parityError),
    .o_frame_error         (frameError)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input ph_t ph, input int tick, input logic rx);
    exp_t e;
    e.ph       = ph;
    e.tick     = tick;
    e.rx       = rx;
    e.samp     = (ph != PH_IDLE) && (ph != PH_DONE);
    e.startChk = (ph == PH_START) && (tick == MID);
    e.deser    = (ph == PH_DATA)  && (tick == MID);
    e.parChk   = (ph == PH_PAR)   && (tick == MID);
    e.stopChk  = (ph == PH_STOP)  && (tick == MID);
    e.valid    = 1'b0;
    e.parErr   = 1'b0;
    e.frmErr   = 1'b0;
    return e;
  endfunction

  function automatic logic [10:0] packExp(input exp_t e);
    return {e.samp, 3'(e.tick), e.deser, e.startChk, e.parChk, e.stopChk,
            e.valid, e.parErr, e.frmErr};
  endfunction

  function automatic logic [10:0] dutVec();
    return {samplerEn, edgeCnt, deserEn, startChkEn, parChkEn, stopChkEn,
            dataValid, parityError, frameError};
  endfunction

  // Expected outputs for cycles 1.. of a frame whose start low is seen on cycle 0.
  task automatic buildFrame(input logic glitch, input logic pe, input logic parOk,
                            input logic stopErr, input logic [7:0] payload);
    exp_t e;
    int   nStart = glitch ? CAPT + 1 : P;
    for (int t = 0; t < nStart; t++)
      expQ.push_back(mk(PH_START, t, glitch ? (t != 0) : 1'b0));
    if (!glitch) begin
      for (int b = 0; b < W; b++)
        for (int t = 0; t < P; t++) expQ.push_back(mk(PH_DATA, t, payload[b]));
      if (pe)
        for (int t = 0; t < P; t++) expQ.push_back(mk(PH_PAR, t, ^payload ^ ~parOk));
      for (int t = 0; t <= CAPT; t++) expQ.push_back(mk(PH_STOP, t, ~stopErr));
      e        = mk(PH_DONE, 0, 1'b1);
      e.parErr = pe & ~parOk;
      e.frmErr = stopErr;
      e.valid  = ~e.parErr & ~e.frmErr;
      expQ.push_back(e);
    end
    expQ.push_back(mk(PH_IDLE, 0, 1'b1));
  endtask

  always @(negedge clk) begin : cmpBlk
    exp_t        e;
    logic [10:0] want, got;
    if (frameId != seenId) begin
      seenId    = frameId;
      cyc       = 0;
      validCyc  = -1;
      parErrCyc = -1;
      frmErrCyc = -1;
      deserCnt  = 0;
      strobeCnt = 0;
    end
    cyc++;
    if (expQ.size() > 0) e = expQ.pop_front();
    else                 e = mk(PH_IDLE, 0, 1'b1);
    curEntry = e;
    want = packExp(e);
    got  = dutVec();
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL outputs frame=%0d cyc=%0d phase=%s tick=%0d got=%b want=%b",
               frameId, cyc, e.ph.name(), e.tick, got, want);
    end
    if (dataValid   && validCyc  < 0) validCyc  = cyc;
    if (parityError && parErrCyc < 0) parErrCyc = cyc;
    if (frameError  && frmErrCyc < 0) frmErrCyc = cyc;
    deserCnt  += int'(deserEn);
    strobeCnt += int'(deserEn) + int'(startChkEn) + int'(parChkEn) + int'(stopChkEn);
  end

  task automatic checkOutput(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Advance one cycle; checker results are only meaningful on the CAPT tick, so
  // they are random everywhere else.
  task automatic stepCycle();
    @(negedge clk);
    #1;
    parityEnable = 1'($urandom_range(0, 1));
    startGlitch  = 1'($urandom_range(0, 1));
    parityOk     = 1'($urandom_range(0, 1));
    stopError    = 1'($urandom_range(0, 1));
    case (curEntry.ph)
      PH_IDLE: rxIn = 1'b1;
      PH_DONE: rxIn = 1'($urandom_range(0, 1));
      default: rxIn = curEntry.rx;
    endcase
    if (curEntry.tick == CAPT) begin
      if (curEntry.ph == PH_START) startGlitch = fGlitch;
      if (curEntry.ph == PH_PAR)   parityOk    = fParOk;
      if (curEntry.ph == PH_STOP)  stopError   = fStopErr;
    end
  endtask

  task automatic startFrame(input logic glitch, input logic pe, input logic parOk,
                            input logic stopErr, input logic [7:0] payload, input int gap);
    int guard = 0;
    while (curEntry.ph != PH_IDLE && guard < 300) begin
      stepCycle();
      guard++;
    end
    if (guard >= 300) checkOutput("idle-timeout", 0, 1);
    for (int g = 0; g < gap; g++) stepCycle();
    fGlitch      = glitch;
    fParOk       = parOk;
    fStopErr     = stopErr;
    rxIn         = 1'b0;
    parityEnable = pe;
    buildFrame(glitch, pe, parOk, stopErr, payload);
    frameId++;
  endtask

  task automatic applyStimulus(input logic glitch, input logic pe, input logic parOk,
                               input logic stopErr, input logic [7:0] payload, input int gap);
    int guard = 0;
    startFrame(glitch, pe, parOk, stopErr, payload, gap);
    do begin
      stepCycle();
      guard++;
    end while (curEntry.ph != PH_IDLE && guard < 300);
    if (guard >= 300) checkOutput("frame-timeout", 0, 1);
  endtask

  initial begin
    rstN = 1'b1; rxIn = 1'b1; parityEnable = 1'b0;
    startGlitch = 1'b0; parityOk = 1'b0; stopError = 1'b0;
    fGlitch = 1'b0; fParOk = 1'b0; fStopErr = 1'b0;
    curEntry = mk(PH_IDLE, 0, 1'b1);
    #2 rstN = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset-outputs", int'(dutVec()), 0);
    rstN = 1'b1;

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 2);
    checkOutput("a5-valid-cycle", validCyc, 81);
    checkOutput("a5-deser-strobes", deserCnt, 8);
    checkOutput("a5-no-frame-error", frmErrCyc, -1);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 0);
    checkOutput("3c-parok-valid-cycle", validCyc, 89);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 1);
    checkOutput("3c-parbad-error-cycle", parErrCyc, 89);
    checkOutput("3c-parbad-no-valid", validCyc, -1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1);
    checkOutput("glitch-strobes", strobeCnt, 1);
    checkOutput("glitch-no-valid", validCyc, -1);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 0);
    checkOutput("both-err-parity-cycle", parErrCyc, 89);
    checkOutput("both-err-frame-cycle", frmErrCyc, 89);
    checkOutput("both-err-no-valid", validCyc, -1);

    // Reset lands mid-DATA; the following frame must start from bit 0 again.
    startFrame(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1);
    for (int k = 0; k < 30; k++) stepCycle();
    checkOutput("pre-reset-sampler", int'(samplerEn), 1);
    rstN = 1'b0;
    expQ.delete();
    #1;
    checkOutput("async-reset-outputs", int'(dutVec()), 0);
    stepCycle();
    stepCycle();
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 0);
    checkOutput("post-reset-valid-cycle", validCyc, 81);
    checkOutput("post-reset-deser-strobes", deserCnt, 8);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end
    stepCycle();
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
